// File: rtl/picorv32_axil_master.sv
// picorv32_axil_master
//   Bridges the PicoRV32 native memory port onto an AXI4-Lite master. Each
//   accepted mem_valid request becomes exactly one AXI-Lite read or write,
//   and the result is handed back to the CPU with a one-cycle mem_ready.
//
// Ports
//   clk, reset                  clock, asynchronous active-high reset
//   mem_valid/instr/addr/       CPU request (sampled only in IDLE)
//   wdata/wstrb
//   mem_ready, mem_rdata        one-cycle completion pulse and read data
//   m_aw*/m_w*/m_b*             AXI-Lite write address, data, response
//   m_ar*/m_r*                  AXI-Lite read address and data
//   err, err_clr                sticky error flag and its synchronous clear
//
// Parameters
//   TIMEOUT   cycles allowed per transaction before abort, 0 disables
//   ERR_DATA  value returned on mem_rdata for a failed or aborted read
module picorv32_axil_master #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic [31:0] m_awaddr,
  output logic [2:0]  m_awprot,
  output logic        m_awvalid,
  input  logic        m_awready,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_wstrb,
  output logic        m_wvalid,
  input  logic        m_wready,
  input  logic [1:0]  m_bresp,
  input  logic        m_bvalid,
  output logic        m_bready,
  output logic [31:0] m_araddr,
  output logic [2:0]  m_arprot,
  output logic        m_arvalid,
  input  logic        m_arready,
  input  logic [31:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rvalid,
  output logic        m_rready,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [2:0] {
    IDLE,
    WADDR,
    WRESP,
    RADDR,
    RDATA,
    DONE
  } state_t;

  state_t      r_state;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [2:0]  r_arprot;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_arvalid;
  logic        r_rready;
  logic        r_awdone;
  logic        r_wdone;
  logic        r_memready;
  logic [31:0] r_rdata;
  logic        r_err;
  logic [31:0] r_count;

  state_t      w_state_n;
  logic        w_awvalid_n;
  logic        w_wvalid_n;
  logic        w_bready_n;
  logic        w_arvalid_n;
  logic        w_rready_n;
  logic        w_awdone_n;
  logic        w_wdone_n;
  logic        w_memready_n;
  logic [31:0] w_rdata_n;
  logic [31:0] w_count_n;
  logic        w_errset;
  logic        w_load;
  logic        w_timeout;

  // Only bit 1 of a response distinguishes SLVERR/DECERR from OKAY/EXOKAY,
  // and the low address bits are dropped by word alignment.
  logic w_unused;
  assign w_unused = ^{m_bresp[0], m_rresp[0], mem_addr[1:0]};

  // Abort fires when the per-transaction counter reaches TIMEOUT; a zero
  // TIMEOUT disables it so slow slaves can be waited on indefinitely.
  assign w_timeout = (TIMEOUT != 0) && (r_count == TIMEOUT);

  // Next-state and next-output logic. Every AXI and CPU output is a flop,
  // so this block decides what each one holds in the following cycle.
  // The write path tracks AW and W with separate done flags because a
  // slave may accept them in either order or together.
  always_comb begin
    w_state_n    = r_state;
    w_awvalid_n  = r_awvalid;
    w_wvalid_n   = r_wvalid;
    w_bready_n   = r_bready;
    w_arvalid_n  = r_arvalid;
    w_rready_n   = r_rready;
    w_awdone_n   = r_awdone;
    w_wdone_n    = r_wdone;
    w_memready_n = 1'b0;
    w_rdata_n    = r_rdata;
    w_count_n    = r_count;
    w_errset     = 1'b0;
    w_load       = 1'b0;

    case (r_state)
      IDLE: begin
        if (mem_valid) begin
          w_load     = 1'b1;
          w_count_n  = '0;
          w_awdone_n = 1'b0;
          w_wdone_n  = 1'b0;
          if (mem_wstrb != 4'b0000) begin
            w_state_n   = WADDR;
            w_awvalid_n = 1'b1;
            w_wvalid_n  = 1'b1;
          end else begin
            w_state_n   = RADDR;
            w_arvalid_n = 1'b1;
          end
        end
      end

      DONE: begin
        w_state_n = IDLE;
      end

      default: begin
        w_count_n = r_count + 32'd1;
        if (w_timeout) begin
          // Debug escape: drops valids mid-handshake, slave needs a reset.
          w_awvalid_n  = 1'b0;
          w_wvalid_n   = 1'b0;
          w_bready_n   = 1'b0;
          w_arvalid_n  = 1'b0;
          w_rready_n   = 1'b0;
          w_errset     = 1'b1;
          w_rdata_n    = ERR_DATA;
          w_memready_n = 1'b1;
          w_state_n    = DONE;
        end else begin
          case (r_state)
            WADDR: begin
              w_awdone_n = r_awdone | (r_awvalid & m_awready);
              w_wdone_n  = r_wdone | (r_wvalid & m_wready);
              if (r_awvalid && m_awready) w_awvalid_n = 1'b0;
              if (r_wvalid && m_wready)   w_wvalid_n  = 1'b0;
              if (w_awdone_n && w_wdone_n) begin
                w_state_n  = WRESP;
                w_bready_n = 1'b1;
              end
            end
            WRESP: begin
              if (m_bvalid) begin
                w_bready_n   = 1'b0;
                w_errset     = m_bresp[1];
                w_memready_n = 1'b1;
                w_state_n    = DONE;
              end
            end
            RADDR: begin
              if (m_arready) begin
                w_arvalid_n = 1'b0;
                w_rready_n  = 1'b1;
                w_state_n   = RDATA;
              end
            end
            RDATA: begin
              if (m_rvalid) begin
                w_rready_n   = 1'b0;
                w_rdata_n    = m_rresp[1] ? ERR_DATA : m_rdata;
                w_errset     = m_rresp[1];
                w_memready_n = 1'b1;
                w_state_n    = DONE;
              end
            end
            default: begin
            end
          endcase
        end
      end
    endcase
  end

  // State and output registers. Request fields are captured only when a
  // request is accepted in IDLE, which keeps address, data and strobes
  // stable for as long as any valid is high. A new error outranks a
  // simultaneous clear so an error is never lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_arprot   <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
      r_awdone   <= 1'b0;
      r_wdone    <= 1'b0;
      r_memready <= 1'b0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_n;
      r_awvalid  <= w_awvalid_n;
      r_wvalid   <= w_wvalid_n;
      r_bready   <= w_bready_n;
      r_arvalid  <= w_arvalid_n;
      r_rready   <= w_rready_n;
      r_awdone   <= w_awdone_n;
      r_wdone    <= w_wdone_n;
      r_memready <= w_memready_n;
      r_rdata    <= w_rdata_n;
      r_count    <= w_count_n;
      if (w_load) begin
        r_addr   <= {mem_addr[31:2], 2'b00};
        r_wdata  <= mem_wdata;
        r_wstrb  <= mem_wstrb;
        r_arprot <= {mem_instr, 2'b00};
      end
      if (w_errset) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign mem_ready = r_memready;
  assign mem_rdata = r_rdata;
  assign m_awaddr  = r_addr;
  assign m_awprot  = 3'b000;
  assign m_awvalid = r_awvalid;
  assign m_wdata   = r_wdata;
  assign m_wstrb   = r_wstrb;
  assign m_wvalid  = r_wvalid;
  assign m_bready  = r_bready;
  assign m_araddr  = r_addr;
  assign m_arprot  = r_arprot;
  assign m_arvalid = r_arvalid;
  assign m_rready  = r_rready;
  assign err       = r_err;

endmodule

// File: tb/tb_picorv32_axil_master.sv
// Testbench for picorv32_axil_master. One instance runs with TIMEOUT=8 for
// the transaction, error, abort and reset scenarios; a second instance with
// TIMEOUT=0 confirms the bridge waits on a stalled slave without aborting.
module tb_picorv32_axil_master;

  logic clk;
  logic reset;

  // Instance with an 8-cycle timeout
  logic        memValid, memInstr, memReady, err, errClr;
  logic [31:0] memAddr, memWdata, memRdata;
  logic [3:0]  memWstrb;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  // Instance with the timeout disabled
  logic        zMemValid, zMemInstr, zMemReady, zErr, zErrClr;
  logic [31:0] zMemAddr, zMemWdata, zMemRdata;
  logic [3:0]  zMemWstrb;
  logic [31:0] zAwaddr, zWdata, zAraddr, zRdata;
  logic [2:0]  zAwprot, zArprot;
  logic [3:0]  zWstrb;
  logic [1:0]  zBresp, zRresp;
  logic        zAwvalid, zAwready, zWvalid, zWready, zBvalid, zBready;
  logic        zArvalid, zArready, zRvalid, zRready;

  int nTotal = 0;
  int nBad   = 0;

  picorv32_axil_master #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(memValid), .mem_instr(memInstr), .mem_addr(memAddr),
    .mem_wdata(memWdata), .mem_wstrb(memWstrb),
    .mem_ready(memReady), .mem_rdata(memRdata),
    .m_awaddr(awaddr), .m_awprot(awprot), .m_awvalid(awvalid), .m_awready(awready),
    .m_wdata(wdata), .m_wstrb(wstrb), .m_wvalid(wvalid), .m_wready(wready),
    .m_bresp(bresp), .m_bvalid(bvalid), .m_bready(bready),
    .m_araddr(araddr), .m_arprot(arprot), .m_arvalid(arvalid), .m_arready(arready),
    .m_rdata(rdata), .m_rresp(rresp), .m_rvalid(rvalid), .m_rready(rready),
    .err(err), .err_clr(errClr)
  );

  picorv32_axil_master #(.TIMEOUT(0), .ERR_DATA(32'hDEAD_BEEF)) dutNoTimeout (
    .clk(clk), .reset(reset),
    .mem_valid(zMemValid), .mem_instr(zMemInstr), .mem_addr(zMemAddr),
    .mem_wdata(zMemWdata), .mem_wstrb(zMemWstrb),
    .mem_ready(zMemReady), .mem_rdata(zMemRdata),
    .m_awaddr(zAwaddr), .m_awprot(zAwprot), .m_awvalid(zAwvalid), .m_awready(zAwready),
    .m_wdata(zWdata), .m_wstrb(zWstrb), .m_wvalid(zWvalid), .m_wready(zWready),
    .m_bresp(zBresp), .m_bvalid(zBvalid), .m_bready(zBready),
    .m_araddr(zAraddr), .m_arprot(zArprot), .m_arvalid(zArvalid), .m_arready(zArready),
    .m_rdata(zRdata), .m_rresp(zRresp), .m_rvalid(zRvalid), .m_rready(zRready),
    .err(zErr), .err_clr(zErrClr)
  );

  // 100 MHz clock, first rising edge at 5 ns
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge: outputs seen here are the
  // values held for the new cycle, inputs set here are sampled next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nTotal++;
    if (observed !== expected) begin
      nBad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Present a CPU request to the timeout-enabled instance
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input logic instr);
    memValid = 1'b1;
    memAddr  = addr;
    memWdata = data;
    memWstrb = strb;
    memInstr = instr;
  endtask

  initial begin
    int readyPulses;

    reset = 1'b1;
    memValid = 0; memInstr = 0; memAddr = 0; memWdata = 0; memWstrb = 0; errClr = 0;
    awready = 0; wready = 0; bresp = 0; bvalid = 0;
    arready = 0; rdata = 0; rresp = 0; rvalid = 0;
    zMemValid = 0; zMemInstr = 0; zMemAddr = 0; zMemWdata = 0; zMemWstrb = 0; zErrClr = 0;
    zAwready = 0; zWready = 0; zBresp = 0; zBvalid = 0;
    zArready = 0; zRdata = 0; zRresp = 0; zRvalid = 0;

    repeat (3) step();

    // Reset values
    checkOutput("rstArvalid", arvalid, 0);
    checkOutput("rstAwvalid", awvalid, 0);
    checkOutput("rstWvalid", wvalid, 0);
    checkOutput("rstBready", bready, 0);
    checkOutput("rstRready", rready, 0);
    checkOutput("rstMemReady", memReady, 0);
    checkOutput("rstMemRdata", memRdata, 0);
    checkOutput("rstErr", err, 0);
    checkOutput("rstAwaddr", awaddr, 0);

    reset = 1'b0;
    step();

    // Read with a zero-wait slave; mem_valid stays high through DONE
    applyStimulus(32'h4000_0004, 32'h0, 4'h0, 1'b0);
    step();
    checkOutput("rdArvalidC1", arvalid, 1);
    checkOutput("rdAraddr", araddr, 32'h4000_0004);
    checkOutput("rdArprot", arprot, 3'b000);
    checkOutput("rdAwvalidC1", awvalid, 0);
    arready = 1;
    step();
    checkOutput("rdArvalidC2", arvalid, 0);
    checkOutput("rdRreadyC2", rready, 1);
    checkOutput("rdMemReadyC2", memReady, 0);
    arready = 0; rvalid = 1; rdata = 32'h1234_5678; rresp = 2'b00;
    step();
    checkOutput("rdMemReadyC3", memReady, 1);
    checkOutput("rdMemRdata", memRdata, 32'h1234_5678);
    checkOutput("rdErr", err, 0);
    checkOutput("rdRreadyC3", rready, 0);
    rvalid = 0;
    step();
    checkOutput("rdMemReadyC4", memReady, 0);
    checkOutput("rdNoReacceptC4", arvalid, 0);
    memValid = 0;
    step();

    // Write where W is accepted in cycle 1 and AW only in cycle 4
    applyStimulus(32'h4000_0010, 32'hA5A5_0001, 4'b0011, 1'b0);
    step();
    checkOutput("wrAwvalidC1", awvalid, 1);
    checkOutput("wrWvalidC1", wvalid, 1);
    checkOutput("wrAwaddr", awaddr, 32'h4000_0010);
    checkOutput("wrAwprot", awprot, 3'b000);
    checkOutput("wrWdata", wdata, 32'hA5A5_0001);
    checkOutput("wrWstrbC1", wstrb, 4'b0011);
    wready = 1;
    step();
    checkOutput("wrWvalidC2", wvalid, 0);
    checkOutput("wrAwvalidC2", awvalid, 1);
    checkOutput("wrBreadyC2", bready, 0);
    wready = 0;
    step();
    checkOutput("wrAwvalidC3", awvalid, 1);
    step();
    checkOutput("wrAwvalidC4", awvalid, 1);
    checkOutput("wrWstrbC4", wstrb, 4'b0011);
    awready = 1;
    step();
    checkOutput("wrAwvalidC5", awvalid, 0);
    checkOutput("wrBreadyC5", bready, 1);
    checkOutput("wrMemReadyC5", memReady, 0);
    awready = 0; bvalid = 1; bresp = 2'b00;
    step();
    checkOutput("wrMemReadyC6", memReady, 1);
    checkOutput("wrBreadyC6", bready, 0);
    checkOutput("wrErr", err, 0);
    bvalid = 0; memValid = 0;
    step();
    checkOutput("wrMemReadyC7", memReady, 0);

    // Read with SLVERR; err_clr in the same cycle loses to the new error
    applyStimulus(32'h4000_0008, 32'h0, 4'h0, 1'b0);
    step();
    arready = 1;
    step();
    arready = 0; rvalid = 1; rdata = 32'h1111_1111; rresp = 2'b10; errClr = 1;
    step();
    checkOutput("rdErrMemReady", memReady, 1);
    checkOutput("rdErrMemRdata", memRdata, 32'hDEAD_BEEF);
    checkOutput("rdErrFlag", err, 1);
    rvalid = 0; rresp = 0; errClr = 0; memValid = 0;
    step();
    checkOutput("rdErrSticky", err, 1);
    errClr = 1;
    step();
    errClr = 0;
    checkOutput("rdErrCleared", err, 0);

    // Write with DECERR
    applyStimulus(32'h4000_000C, 32'h0000_0001, 4'hF, 1'b0);
    step();
    awready = 1; wready = 1;
    step();
    checkOutput("wrErrBready", bready, 1);
    checkOutput("wrErrAwvalid", awvalid, 0);
    checkOutput("wrErrWvalid", wvalid, 0);
    awready = 0; wready = 0; bvalid = 1; bresp = 2'b11;
    step();
    checkOutput("wrErrMemReady", memReady, 1);
    checkOutput("wrErrFlag", err, 1);
    bvalid = 0; bresp = 0; memValid = 0;
    step();
    errClr = 1;
    step();
    errClr = 0;
    checkOutput("wrErrCleared", err, 0);

    // Timeout: slave never accepts AR, abort lands in cycle 10
    applyStimulus(32'h4000_0020, 32'h0, 4'h0, 1'b0);
    step();
    repeat (8) step();
    checkOutput("toArvalidC9", arvalid, 1);
    checkOutput("toMemReadyC9", memReady, 0);
    checkOutput("toErrC9", err, 0);
    step();
    checkOutput("toArvalidC10", arvalid, 0);
    checkOutput("toMemReadyC10", memReady, 1);
    checkOutput("toMemRdata", memRdata, 32'hDEAD_BEEF);
    checkOutput("toErrC10", err, 1);
    memValid = 0;
    step();
    checkOutput("toMemReadyC11", memReady, 0);
    errClr = 1;
    step();
    errClr = 0;

    // Instruction fetch from an unaligned address
    applyStimulus(32'h6000_0003, 32'h0, 4'h0, 1'b1);
    step();
    checkOutput("ifAraddr", araddr, 32'h6000_0000);
    checkOutput("ifArprot", arprot, 3'b100);
    arready = 1;
    step();
    arready = 0; rvalid = 1; rdata = 32'hCAFE_F00D; rresp = 2'b00;
    step();
    checkOutput("ifMemReady", memReady, 1);
    checkOutput("ifMemRdata", memRdata, 32'hCAFE_F00D);
    rvalid = 0; memValid = 0; memInstr = 0;
    step();

    // Reset raised between clock edges while waiting in WRESP
    applyStimulus(32'h4000_0030, 32'h0000_0055, 4'h1, 1'b0);
    step();
    awready = 1; wready = 1;
    step();
    checkOutput("rmBreadyBefore", bready, 1);
    awready = 0; wready = 0;
    #3 reset = 1'b1;
    #1;
    checkOutput("rmBreadyAsync", bready, 0);
    checkOutput("rmAwvalidAsync", awvalid, 0);
    checkOutput("rmMemReadyAsync", memReady, 0);
    memValid = 0;
    step();
    step();
    reset = 1'b0;
    step();
    applyStimulus(32'h4000_0040, 32'h0, 4'h0, 1'b0);
    step();
    checkOutput("rmNextArvalid", arvalid, 1);
    checkOutput("rmNextAraddr", araddr, 32'h4000_0040);
    arready = 1;
    step();
    arready = 0; rvalid = 1; rdata = 32'h0BAD_F00D;
    step();
    checkOutput("rmNextMemReady", memReady, 1);
    checkOutput("rmNextMemRdata", memRdata, 32'h0BAD_F00D);
    checkOutput("rmNextErr", err, 0);
    rvalid = 0; memValid = 0;
    step();

    // Timeout disabled: a stalled AR is held for 1000 cycles
    zMemValid = 1; zMemAddr = 32'h4000_0050; zMemWstrb = 4'h0;
    step();
    readyPulses = 0;
    for (int i = 0; i < 1000; i++) begin
      if (zMemReady) readyPulses++;
      step();
    end
    checkOutput("ntReadyPulses", readyPulses, 0);
    checkOutput("ntArvalidHeld", zArvalid, 1);
    checkOutput("ntErr", zErr, 0);
    zArready = 1;
    step();
    zArready = 0; zRvalid = 1; zRdata = 32'h600D_CAFE;
    step();
    checkOutput("ntMemReady", zMemReady, 1);
    checkOutput("ntMemRdata", zMemRdata, 32'h600D_CAFE);
    zRvalid = 0; zMemValid = 0;
    step();

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule

// File: doc/picorv32_axil_master.md
# picorv32_axil_master

Bridge between the PicoRV32 native memory port and an AXI4-Lite master interface. It turns each `mem_valid` request in the accelerator address windows into one AXI-Lite read or write transaction and returns the result to the CPU. It sits between the CPU-side address decode and the accelerator AXI-Lite slaves (UART, fpsqrt, crc32 wrappers). It replaces the direct memory-mapped accelerator path.

## Interface
- TIMEOUT, 255: cycles allowed per transaction before abort; 0 disables the timeout.
- ERR_DATA, 32'hDEAD_BEEF: value returned on `mem_rdata` for a failed read.
- clk  in  1  system clock (pl_clk0, 100 MHz)
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  CPU request valid; held until `mem_ready`
- mem_instr  in  1  request is an instruction fetch
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte enables; 0 means read
- mem_ready  out  1  one-cycle completion pulse
- mem_rdata  out  32  read data, valid while `mem_ready`=1
- m_awaddr/m_awprot/m_awvalid/m_awready  out/out/out/in  32/3/1/1  AW channel
- m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  32/4/1/1  W channel
- m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  B channel
- m_araddr/m_arprot/m_arvalid/m_arready  out/out/out/in  32/3/1/1  AR channel
- m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  32/2/1/1  R channel
- err  out  1  sticky error flag
- err_clr  in  1  synchronous clear of `err`

## Operation
- FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, DONE.
- **IDLE:** on `mem_valid`, latch the request:
  - address = {mem_addr[31:2],2'b00}, plus `wdata`, `wstrb` and `instr`.
  - `mem_wstrb`≠0 → WADDR; else → RADDR.
- **WADDR:**
  - `m_awvalid` and `m_wvalid` both assert on entry.
  - Each deasserts independently after its own handshake (valid&ready at a clock edge).
  - Two done flags track the channels. When both are done (same or different cycles) → WRESP.
- **WRESP:** `m_bready`=1. On `m_bvalid`, `m_bresp[1]`=1 sets `err`. → DONE.
- **RADDR:** `m_arvalid`=1 until `m_arready` → RDATA.
- **RDATA:** `m_rready`=1. On `m_rvalid`, capture `m_rdata`, or ERR_DATA if `m_rresp[1]`=1 (which also sets `err`). → DONE.
- **DONE:** `mem_ready`=1 for exactly one cycle → IDLE. A request is never accepted in DONE.
- **Protection bits:** `m_awprot`=3'b000; `m_arprot`={mem_instr,2'b00}.
- **Timeout counter:**
  - Clears on leaving IDLE and increments each cycle in WADDR/WRESP/RADDR/RDATA.
  - When count == TIMEOUT (TIMEOUT≠0): all AXI valid/ready outputs drop next cycle, `err` sets, `mem_rdata`=ERR_DATA → DONE.
  - This abort intentionally violates AXI valid-hold and is a debug escape only. The slave must be reset before further use.
- **`err` precedence:** `err` set has priority over `err_clr` in the same cycle.
- **Outputs:** all AXI outputs are registered. Address, data and strobes remain stable while the corresponding valid is high.
- **Single outstanding:** at most one outstanding transaction. `mem_*` inputs are ignored outside IDLE.

## Timing
- **Reset values** (asserted asynchronously, released synchronously to clk): state=IDLE, all valid/ready outputs 0, `mem_ready`=0, `mem_rdata`=0, `err`=0, counter=0, addr/data regs 0.
- **Reset mid-transaction:** immediate return to IDLE with all outputs at reset values. The CPU is reset by the same reset.
- **Minimum read:**
  - `mem_valid` rises in cycle 0; `m_arvalid` high in cycle 1.
  - With `m_arready`=1 in cycle 1 and `m_rvalid`=1 in cycle 2, `mem_ready`=1 in cycle 3.
- **Minimum write:** same profile. AW+W handshake in cycle 1, `m_bvalid` in cycle 2, `mem_ready` in cycle 3.
- **Back-to-back:** the CPU drops `mem_valid` the cycle after `mem_ready`, so the next request is sampled in IDLE no earlier than cycle 4 (4-cycle minimum per access).
- **Abort timing:** the timeout abort asserts `mem_ready` at cycle TIMEOUT+2 after leaving IDLE.

## Test plan
- **Read, zero-wait slave:** addr 0x4000_0004, slave returns 0x1234_5678 OKAY → `m_araddr`=0x4000_0004, `m_arprot`=000, `mem_ready` in cycle 3, `mem_rdata`=0x1234_5678, `err`=0.
- **Write, W before AW:** wdata 0xA5A5_0001, wstrb 4'b0011; `m_wready` in cycle 1, `m_awready` in cycle 4 → `m_wvalid` drops after cycle 1, `m_awvalid` held to cycle 4, `m_bready` from cycle 5, `mem_ready` one cycle after `m_bvalid`, `m_wstrb`=0011 throughout.
- **Error responses:** read with `m_rresp`=2'b10 → `mem_rdata`=0xDEAD_BEEF, `err`=1; write with `m_bresp`=2'b11 → `err`=1. Pulse `err_clr` → `err`=0.
- **Timeout:** TIMEOUT=8, slave never asserts `m_arready` → `m_arvalid` drops and `mem_ready`=1 with 0xDEAD_BEEF at cycle 10 after leaving IDLE, `err`=1. With TIMEOUT=0 the bridge waits indefinitely (checked to 1000 cycles).
- **Reset mid-transaction:** `reset` asserted during WRESP, between clock edges → `m_bready`, `m_awvalid`, `mem_ready` go 0 without waiting for a clock edge; the next read after release completes normally.
- **Instruction fetch:** `mem_instr`=1 read of 0x6000_0000 → `m_arprot`=3'b100, unaligned `mem_addr` 0x6000_0003 → `m_araddr`=0x6000_0000.
